mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Memory-stage load/store unit. Consumes the exe stage's memory request (mem_we/addr/data/op) via exe_mem.
//  Executes the access on a word-wide data-memory bus with a req/gnt/rvalid handshake.
//  Aligns and sign/zero-extends load data; forwards the writeback triple to mem_wb.
//  Holds the pipeline through pipe_ctrl (stallreq_o) for every bus access.
// PARAMETERS
//  ADDR_WIDTH      32   byte address width
//  DATA_WIDTH      32   bus/register data width (only 32 supported)
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before abort; 0 disables timeout
// PORTS
//  clk_i         in   1   clock
//  rst_i         in   1   synchronous active-high reset
//  mem_we_i      in   1   store flag from exe_mem
//  mem_addr_i    in   32  byte address
//  mem_data_i    in   32  store data (rs2, unaligned)
//  mem_op_i      in   4   `MEM_NOP=0 LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8
//  reg_waddr_i   in   5   rd
//  reg_we_i      in   1   rd write enable
//  reg_wdata_i   in   32  exe result (used when not a load)
//  reg_waddr_o   out  5   to mem_wb
//  reg_we_o      out  1   to mem_wb
//  reg_wdata_o   out  32  to mem_wb
//  stallreq_o    out  1   to pipe_ctrl; combinational
//  misalign_o    out  1   1-cycle pulse: misaligned access dropped
//  bus_err_o     out  1   1-cycle pulse: access aborted by timeout
//  bus_req_o     out  1   bus request
//  bus_we_o      out  1   1=write
//  bus_addr_o    out  32  word address ({addr[31:2],2'b00})
//  bus_wdata_o   out  32  lane-replicated write data
//  bus_be_o      out  4   byte enables
//  bus_gnt_i     in   1   request accepted this cycle
//  bus_rvalid_i  in   1   read data valid this cycle
//  bus_rdata_i   in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-access aborts silently.
//   bus_req_o drops after the reset edge; a late rvalid arriving in IDLE is ignored.
//  FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//  IDLE:
//   - mem_op_i==NOP: registers reg_*_i into reg_*_o each cycle (1-cycle latency); stallreq_o=0.
//   - Aligned mem op: latches op/addr/data/rd/we, goes to REQ; stallreq_o=1 in this same cycle.
//   - Misaligned op (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus access, no stall.
//     Next cycle: misalign_o=1, reg_we_o=0.
//  REQ: bus_req_o=1, bus_* driven from latched request and held stable until bus_gnt_i.
//   - On gnt: a store goes to DONE; a load goes to WAIT.
//   - bus_rvalid_i in the same cycle as gnt is legal: a load then goes directly to DONE with the data.
//  WAIT: bus_req_o=0; on bus_rvalid_i captures the extracted load value and goes to DONE.
//  DONE: stallreq_o=0; the latched instruction retires.
//   - Load: reg_wdata_o = extracted value, reg_we_o = latched we.
//   - Store: reg_we_o=0.
//   - Inputs in DONE are still the retiring instruction and never start a new access.
//  stallreq_o = 1 in REQ and WAIT, and in IDLE when an aligned mem op is present; 0 otherwise.
//  While stalled (REQ/WAIT and the entry cycle), reg_we_o registers 0 so mem_wb sees a bubble.
//  Byte enables:
//   - SB: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
//   - SH: be = 4'b0011 << addr[1:0]; wdata = {2{data[15:0]}}.
//   - SW: be = 4'b1111.
//   - Loads: be = 4'b1111.
//  Load extract: lane = rdata >> (8*addr[1:0]).
//   - LB/LH sign-extend lane[7:0]/lane[15:0]; LBU/LHU zero-extend; LW uses rdata unchanged.
//  Timeout: the counter increments each cycle in REQ/WAIT and clears in IDLE.
//   - On reaching TIMEOUT_CYCLES: goes to DONE with reg_we_o=0, bus_err_o pulses 1 cycle, bus_req_o drops.
//  Address arithmetic: no wrap handling; address 32'hFFFF_FFFC is a valid word.
// TESTING
//  LW addr=0x100, gnt at cycle 2, rvalid rdata=0xDEADBEEF at cycle 4
//   -> stall 4 cycles, then reg_wdata_o=0xDEADBEEF, reg_we_o=1.
//  LB addr=0x103, rdata=0x80FF_0000 -> reg_wdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  SH addr=0x202 data=0x1234_ABCD -> bus_be_o=4'b1100, bus_wdata_o=0xABCD_ABCD, bus_we_o=1; reg_we_o=0.
//  LW addr=0x101 -> no bus_req_o, no stall, misalign_o=1 next cycle, reg_we_o=0.
//  ADDI result 0x55 to x5 (NOP op) -> next cycle reg_waddr_o=5, reg_wdata_o=0x55, reg_we_o=1.
//  Faults: gnt never asserted, TIMEOUT_CYCLES=8 -> bus_err_o after 8 stall cycles;
//   rst_i asserted in WAIT -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-stage load/store unit with req/gnt/rvalid data bus and timeout abort
module mem_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [3:0]            mem_op_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stallreq_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                state;
    logic [3:0]            op_q;
    logic [1:0]            off_q;
    logic [4:0]            rd_q;
    logic                  we_q;
    logic                  store_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] load_q;
    logic [CW-1:0]         cnt_q;

    logic                  is_mem;
    logic                  misaligned;
    logic                  start;
    logic [3:0]            be_in;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] load_val;

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [3:0] op, input logic [1:0] off,
                                                      input logic [DATA_WIDTH-1:0] rdata);
        logic [DATA_WIDTH-1:0] lane;
        lane = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   return {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            OP_LH:   return {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            OP_LBU:  return {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            OP_LHU:  return {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        is_mem = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: misaligned = mem_addr_i[0];
            OP_LW, OP_SW:         misaligned = |mem_addr_i[1:0];
            default:              misaligned = 1'b0;
        endcase
        start    = is_mem && !misaligned;
        be_in    = 4'b1111;
        wdata_in = '0;
        case (mem_op_i)
            OP_SB: begin
                be_in    = 4'b0001 << mem_addr_i[1:0];
                wdata_in = {4{mem_data_i[7:0]}};
            end
            OP_SH: begin
                be_in    = 4'b0011 << mem_addr_i[1:0];
                wdata_in = {2{mem_data_i[15:0]}};
            end
            OP_SW:   wdata_in = mem_data_i;
            default: ;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign load_val    = extract(op_q, off_q, bus_rdata_i);
    assign bus_req_o   = (state == S_REQ);
    assign stallreq_o  = (state == S_REQ) || (state == S_WAIT) || ((state == S_IDLE) && start);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= '0;
            cnt_q       <= '0;
            reg_waddr_o <= '0;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= '0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt_q       <= '0;
                    reg_waddr_o <= reg_waddr_i;
                    reg_wdata_o <= reg_wdata_i;
                    if (start) begin
                        // direction comes from mem_we_i; the op only selects lanes and extension
                        op_q        <= mem_op_i;
                        off_q       <= mem_addr_i[1:0];
                        rd_q        <= reg_waddr_i;
                        we_q        <= reg_we_i;
                        store_q     <= mem_we_i;
                        err_q       <= 1'b0;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus_wdata_o <= wdata_in;
                        bus_be_o    <= be_in;
                        reg_we_o    <= 1'b0;
                        state       <= S_REQ;
                    end else if (is_mem) begin
                        misalign_o <= 1'b1;
                        reg_we_o   <= 1'b0;
                    end else begin
                        reg_we_o <= reg_we_i;
                    end
                end
                S_REQ: begin
                    reg_we_o <= 1'b0;
                    if (bus_gnt_i && (store_q || bus_rvalid_i)) begin
                        load_q <= load_val;
                        state  <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        bus_err_o <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (bus_gnt_i) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    reg_we_o <= 1'b0;
                    if (bus_rvalid_i) begin
                        load_q <= load_val;
                        state  <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        bus_err_o <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    reg_waddr_o <= rd_q;
                    reg_wdata_o <= load_q;
                    reg_we_o    <= we_q && !store_q && !err_q;
                    cnt_q       <= '0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - randomized self-checking bench for mem_lsu against a behavioural model
module tb_mem_lsu;

    localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4;
    localparam logic [3:0] LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [3:0]  mem_op_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        reg_we_i = 1'b0;
    logic [31:0] reg_wdata_i = '0;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stallreq_o, misalign_o, bus_err_o, bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    int vectors = 0;
    int miscompares = 0;

    // observations of the most recent run_access
    int          obs_stall, obs_req_cycles;
    logic        obs_hung, obs_bus_changed, obs_entry_req;
    logic [31:0] obs_addr, obs_wdata_bus;
    logic [3:0]  obs_be;
    logic        obs_bwe;
    logic        obs_done_we, obs_done_err, obs_done_req;
    logic        obs_we, obs_mis, obs_err_after, obs_req_after, obs_stall_after;
    logic [31:0] obs_wdata;
    logic [4:0]  obs_waddr;

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_op_i(mem_op_i), .reg_waddr_i(reg_waddr_i),
        .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i), .reg_waddr_o(reg_waddr_o),
        .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o), .stallreq_o(stallreq_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int op_size(input logic [3:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] sh, b;
        sh = rdata >> (8 * (addr % 4));
        case (op)
            LB:  begin b = sh % 256;   return (b >= 128)   ? b + 32'hFFFF_FF00 : b; end
            LH:  begin b = sh % 65536; return (b >= 32768) ? b + 32'hFFFF_0000 : b; end
            LBU: return sh % 256;
            LHU: return sh % 65536;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
        if (op == SB) return 4'(1 << (addr % 4));
        if (op == SH) return 4'(3 << (addr % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] data);
        if (op == SB) return (data % 256) * 32'h0101_0101;
        if (op == SH) return (data % 65536) * 32'h0001_0001;
        return data;
    endfunction

    // Drives one instruction and acts as the bus slave: gnt after g REQ cycles, rvalid r cycles later.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] rd, input logic we, input int g, input int r,
                              input logic [31:0] rdata);
        int  reqc = 0, waitc = 0, cyc = 0;
        bit  granted = 0, rv_sent = 0, first = 1;
        logic is_load;
        is_load = (op < SB);
        obs_stall = 0; obs_req_cycles = 0; obs_bus_changed = 0;
        @(posedge clk); #1;
        mem_op_i = op; mem_addr_i = addr; mem_data_i = data; mem_we_i = !is_load;
        reg_waddr_i = rd; reg_we_i = we; reg_wdata_i = $urandom;
        bus_gnt_i = 0; bus_rvalid_i = 0;
        @(negedge clk);
        obs_entry_req = bus_req_o;
        if (stallreq_o) obs_stall++;
        while (stallreq_o && cyc < 40) begin
            @(posedge clk); #1;
            bus_gnt_i = 0; bus_rvalid_i = 0;
            if (bus_req_o) begin
                if (reqc == g) begin
                    bus_gnt_i = 1; granted = 1;
                    if (is_load && r == 0) bus_rvalid_i = 1;
                end
                reqc++;
            end else if (granted && is_load && !rv_sent) begin
                waitc++;
                if (waitc == r) bus_rvalid_i = 1;
            end
            if (bus_rvalid_i) begin rv_sent = 1; bus_rdata_i = rdata; end
            else bus_rdata_i = $urandom;
            @(negedge clk);
            if (bus_req_o) begin
                obs_req_cycles++;
                if (first) begin
                    obs_addr = bus_addr_o; obs_be = bus_be_o; obs_wdata_bus = bus_wdata_o; obs_bwe = bus_we_o;
                end else if (obs_addr != bus_addr_o || obs_be != bus_be_o ||
                             obs_wdata_bus != bus_wdata_o || obs_bwe != bus_we_o) begin
                    obs_bus_changed = 1;
                end
                first = 0;
            end
            if (stallreq_o) obs_stall++;
            cyc++;
        end
        obs_hung = stallreq_o;
        obs_done_we = reg_we_o; obs_done_err = bus_err_o; obs_done_req = bus_req_o;
        @(posedge clk); #1;
        mem_op_i = 0; mem_we_i = 0; reg_we_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;
        @(negedge clk);
        obs_we = reg_we_o; obs_wdata = reg_wdata_o; obs_waddr = reg_waddr_o; obs_mis = misalign_o;
        obs_err_after = bus_err_o; obs_req_after = bus_req_o; obs_stall_after = stallreq_o;
    endtask

    task automatic test_reset;
        rst_i = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({reg_waddr_o, reg_we_o, reg_wdata_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_reg: got %0h/%0b/%0h, expected 0/0/0", reg_waddr_o, reg_we_o, reg_wdata_o);
        end
        vectors++;
        if ({stallreq_o, misalign_o, bus_err_o, bus_req_o, bus_we_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 00000",
                     {stallreq_o, misalign_o, bus_err_o, bus_req_o, bus_we_o});
        end
        vectors++;
        if ({bus_addr_o, bus_wdata_o, bus_be_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: got %h %h %b, expected zeros", bus_addr_o, bus_wdata_o, bus_be_o);
        end
        @(posedge clk); #1;
        rst_i = 0;
    endtask

    task automatic test_nop;
        logic [4:0]  a;
        logic [31:0] d;
        logic        w;
        for (int i = 0; i < 12; i++) begin
            a = (i == 0) ? 5'd5 : 5'($urandom);
            d = (i == 0) ? 32'h55 : $urandom;
            w = (i == 0) ? 1'b1 : 1'($urandom);
            @(posedge clk); #1;
            mem_op_i = (i % 3 == 2) ? 4'd9 + 4'($urandom_range(0, 6)) : 4'd0;
            mem_we_i = 0; mem_addr_i = $urandom;
            reg_waddr_i = a; reg_wdata_i = d; reg_we_i = w;
            @(negedge clk);
            vectors++;
            if (stallreq_o !== 1'b0) begin
                miscompares++;
                $display("FAIL nop_stall[%0d]: got %b, expected 0", i, stallreq_o);
            end
            @(posedge clk); #1;
            vectors++;
            if (reg_waddr_o !== a || reg_wdata_o !== d || reg_we_o !== w) begin
                miscompares++;
                $display("FAIL nop_pass[%0d]: got %0d/%h/%b, expected %0d/%h/%b",
                         i, reg_waddr_o, reg_wdata_o, reg_we_o, a, d, w);
            end
        end
    endtask

    task automatic test_directed;
        run_access(LW, 32'h100, 32'h0, 5'd9, 1'b1, 0, 2, 32'hDEAD_BEEF);
        vectors++;
        if (obs_stall != 4 || obs_we !== 1'b1 || obs_wdata !== 32'hDEAD_BEEF || obs_waddr !== 5'd9) begin
            miscompares++;
            $display("FAIL lw_basic: got stall=%0d we=%b data=%h rd=%0d, expected 4 1 deadbeef 9",
                     obs_stall, obs_we, obs_wdata, obs_waddr);
        end
        run_access(LB, 32'h103, 32'h0, 5'd3, 1'b1, 1, 1, 32'h80FF_0000);
        vectors++;
        if (obs_wdata !== 32'hFFFF_FF80 || obs_we !== 1'b1) begin
            miscompares++;
            $display("FAIL lb_sign: got %h we=%b, expected ffffff80 1", obs_wdata, obs_we);
        end
        run_access(LBU, 32'h103, 32'h0, 5'd3, 1'b1, 0, 0, 32'h80FF_0000);
        vectors++;
        if (obs_wdata !== 32'h0000_0080 || obs_stall != 2) begin
            miscompares++;
            $display("FAIL lbu_zero: got %h stall=%0d, expected 00000080 2", obs_wdata, obs_stall);
        end
        run_access(SH, 32'h202, 32'h1234_ABCD, 5'd4, 1'b1, 2, 0, 32'h0);
        vectors++;
        if (obs_be !== 4'b1100 || obs_wdata_bus !== 32'hABCD_ABCD || obs_bwe !== 1'b1 ||
            obs_we !== 1'b0 || obs_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL sh_lanes: got be=%b wd=%h we=%b rwe=%b addr=%h, expected 1100 abcdabcd 1 0 200",
                     obs_be, obs_wdata_bus, obs_bwe, obs_we, obs_addr);
        end
        run_access(LW, 32'h101, 32'h0, 5'd6, 1'b1, 0, 0, 32'h0);
        vectors++;
        if (obs_stall != 0 || obs_entry_req !== 1'b0 || obs_req_after !== 1'b0 ||
            obs_mis !== 1'b1 || obs_we !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_misalign: got stall=%0d req=%b/%b mis=%b we=%b, expected 0 0/0 1 0",
                     obs_stall, obs_entry_req, obs_req_after, obs_mis, obs_we);
        end
        run_access(LW, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 0, 1, 32'h0BAD_F00D);
        vectors++;
        if (obs_addr !== 32'hFFFF_FFFC || obs_wdata !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL top_word: got addr=%h data=%h, expected fffffffc 0badf00d", obs_addr, obs_wdata);
        end
    endtask

    task automatic test_random_access;
        logic [3:0]  op;
        logic [31:0] addr, data, rdata;
        logic [4:0]  rd;
        logic        we, mis, st;
        int          g, r, exp_stall;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 8));
            addr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
            data = $urandom; rdata = $urandom; rd = 5'($urandom); we = 1'($urandom);
            g = $urandom_range(0, 3); r = $urandom_range(0, 3);
            st = (op >= SB);
            mis = (addr % op_size(op)) != 0;
            exp_stall = mis ? 0 : (st ? 2 + g : 2 + g + r);
            run_access(op, addr, data, rd, we, g, r, rdata);
            vectors++;
            if (obs_stall != exp_stall || obs_hung !== 1'b0 || obs_mis !== mis ||
                obs_req_cycles != (mis ? 0 : g + 1) || obs_done_err !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_flow[%0d] op=%0d a=%h: got stall=%0d mis=%b req=%0d err=%b, expected %0d %b %0d 0",
                         i, op, addr, obs_stall, obs_mis, obs_req_cycles, obs_done_err,
                         exp_stall, mis, mis ? 0 : g + 1);
            end
            if (!mis) begin
                vectors++;
                if (obs_addr !== (addr & 32'hFFFF_FFFC) || obs_be !== ref_be(op, addr) ||
                    obs_bwe !== st || obs_bus_changed !== 1'b0 ||
                    (st && obs_wdata_bus !== ref_wdata(op, data))) begin
                    miscompares++;
                    $display("FAIL rnd_bus[%0d] op=%0d: got a=%h be=%b we=%b wd=%h chg=%b, expected %h %b %b %h 0",
                             i, op, obs_addr, obs_be, obs_bwe, obs_wdata_bus, obs_bus_changed,
                             addr & 32'hFFFF_FFFC, ref_be(op, addr), st, ref_wdata(op, data));
                end
            end
            vectors++;
            if (obs_we !== (!mis && !st && we) || obs_done_we !== 1'b0 ||
                (!mis && !st && (obs_wdata !== ref_load(op, addr, rdata) || obs_waddr !== rd))) begin
                miscompares++;
                $display("FAIL rnd_wb[%0d] op=%0d: got we=%b bubble=%b data=%h rd=%0d, expected %b 0 %h %0d",
                         i, op, obs_we, obs_done_we, obs_wdata, obs_waddr,
                         !mis && !st && we, ref_load(op, addr, rdata), rd);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] op;
        for (int i = 0; i < 8; i++) begin
            op = (i % 2 == 0) ? SW : LW;
            run_access(op, 32'h3000 + 32'(i * 4), $urandom, 5'(i + 1), 1'b1, 0, 0, $urandom);
            vectors++;
            if (obs_stall_after !== 1'b0 || obs_req_after !== 1'b0 || obs_done_req !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_norestart[%0d]: got stall=%b req=%b/%b, expected 0 0/0",
                         i, obs_stall_after, obs_done_req, obs_req_after);
            end
        end
    endtask

    task automatic test_timeout;
        run_access(LW, 32'h400, 32'h0, 5'd7, 1'b1, 100, 0, 32'h0);
        vectors++;
        if (obs_stall != 9 || obs_req_cycles != 8 || obs_done_err !== 1'b1 || obs_done_req !== 1'b0 ||
            obs_err_after !== 1'b0 || obs_we !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_req: got stall=%0d req=%0d err=%b/%b breq=%b we=%b, expected 9 8 1/0 0 0",
                     obs_stall, obs_req_cycles, obs_done_err, obs_err_after, obs_done_req, obs_we);
        end
        run_access(LHU, 32'h402, 32'h0, 5'd8, 1'b1, 2, 100, 32'h0);
        vectors++;
        if (obs_stall != 9 || obs_req_cycles != 3 || obs_done_err !== 1'b1 || obs_we !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_wait: got stall=%0d req=%0d err=%b we=%b, expected 9 3 1 0",
                     obs_stall, obs_req_cycles, obs_done_err, obs_we);
        end
        run_access(LH, 32'h406, 32'h0, 5'd2, 1'b1, 3, 3, 32'h8001_0000);
        vectors++;
        if (obs_done_err !== 1'b0 || obs_we !== 1'b1 || obs_wdata !== 32'hFFFF_8001) begin
            miscompares++;
            $display("FAIL timeout_recover: got err=%b we=%b data=%h, expected 0 1 ffff8001",
                     obs_done_err, obs_we, obs_wdata);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        mem_op_i = LW; mem_we_i = 0; mem_addr_i = 32'h500; reg_waddr_i = 5'd10; reg_we_i = 1;
        @(posedge clk); #1;
        bus_gnt_i = 1;
        @(posedge clk); #1;
        bus_gnt_i = 0;
        @(posedge clk); #1;
        rst_i = 1; mem_op_i = 0; reg_we_i = 0;
        @(posedge clk); #1;
        rst_i = 0;
        vectors++;
        if ({reg_waddr_o, reg_we_o, reg_wdata_o, stallreq_o, misalign_o, bus_err_o, bus_req_o,
             bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got we=%b req=%b stall=%b addr=%h be=%b, expected all zero",
                     reg_we_o, bus_req_o, stallreq_o, bus_addr_o, bus_be_o);
        end
        bus_rvalid_i = 1; bus_rdata_i = 32'hCAFE_0000;
        reg_waddr_i = 5'd3; reg_wdata_i = 32'h77; reg_we_i = 1;
        @(posedge clk); #1;
        bus_rvalid_i = 0;
        vectors++;
        if (reg_wdata_o !== 32'h77 || reg_we_o !== 1'b1 || reg_waddr_o !== 5'd3 ||
            bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL late_rvalid: got data=%h we=%b rd=%0d req=%b stall=%b, expected 77 1 3 0 0",
                     reg_wdata_o, reg_we_o, reg_waddr_o, bus_req_o, stallreq_o);
        end
    endtask

    initial begin
        test_reset;
        test_nop;
        test_directed;
        test_random_access;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
